// File: rtl/battleship_screen_pkg.sv
// Shared definitions for the battleship screen sequencer.
//   - Screen code bit positions (START, HIT, MISS, WIN_k, PLAY).
//   - Sequencer state encoding.
//   - Lowest-set-bit priority encoder used for both shooter and winner selection.
package battleship_screen_pkg;

   localparam int unsigned MAX_PLAYERS  = 8;
   localparam int unsigned MAX_IDX_W    = 3;

   localparam int unsigned SCR_START    = 0;
   localparam int unsigned SCR_HIT      = 1;
   localparam int unsigned SCR_MISS     = 2;
   localparam int unsigned SCR_WIN_BASE = 3;

   typedef enum logic [2:0] {
      StStart,
      StPlay,
      StWait,
      StShow,
      StWin
   } state_e;

   // PLAY sits directly above the last WIN bit.
   function automatic int unsigned scr_play(input int unsigned n);
      return SCR_WIN_BASE + n;
   endfunction

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [MAX_IDX_W-1:0] lowest_set(input logic [MAX_PLAYERS-1:0] vec);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
         if (vec[i]) idx = MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter used for both the HIT/MISS hold and the shot-result timeout.
//   clk, rst_n   : clock, async active-low reset
//   load_i       : load load_val_i (has priority over dec_i)
//   load_val_i   : reload value
//   dec_i        : decrement by one, saturating at zero
//   value_o      : current count
//   expire_o     : count is one, i.e. this is the last cycle of the interval
module hold_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] value_o,
   output logic             expire_o
);

   logic [WIDTH-1:0] value_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else if (load_i) begin
         value_q <= load_val_i;
      end else if (dec_i && (value_q != '0)) begin
         value_q <= value_q - WIDTH'(1);
      end
   end

   assign value_o  = value_q;
   assign expire_o = (value_q == WIDTH'(1));

endmodule

// File: rtl/screen_sequencer.sv
// Registered screen selector for the battleship display path.
// Tracks turn state, latches the shooter, holds HIT/MISS screens, times out
// unanswered shots and latches the winner screen until a new game.
//   clk, rst_n    : clock, async active-low reset
//   start_i       : game setup / restart level
//   fire_i        : per-player fire pulse
//   hit_i, miss_i : per-defender shot result
//   wins_i        : per-player win level
//   screen_o      : one-hot screen code (START, HIT, MISS, WIN_k..., PLAY)
//   shooter_o     : index of the last accepted shooter
//   screen_chg_o  : pulse in the cycle screen_o takes a new value
//   timeout_o     : pulse when a shot result times out
module screen_sequencer
   import battleship_screen_pkg::*;
#(
   parameter int unsigned NUM_PLAYERS    = 2,
   parameter int unsigned HOLD_CYCLES    = 50_000_000,
   parameter int unsigned RESULT_TIMEOUT = 1_000_000,
   localparam int unsigned SCREEN_W      = NUM_PLAYERS + 4,
   localparam int unsigned IDX_W         = $clog2(NUM_PLAYERS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic [NUM_PLAYERS-1:0] fire_i,
   input  logic [NUM_PLAYERS-1:0] hit_i,
   input  logic [NUM_PLAYERS-1:0] miss_i,
   input  logic [NUM_PLAYERS-1:0] wins_i,
   output logic [SCREEN_W-1:0]    screen_o,
   output logic [IDX_W-1:0]       shooter_o,
   output logic                   screen_chg_o,
   output logic                   timeout_o
);

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > RESULT_TIMEOUT) ? HOLD_CYCLES : RESULT_TIMEOUT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_e               state_q, state_d;
   logic                 show_hit_q, show_hit_d;
   logic [IDX_W-1:0]     shooter_q, shooter_d;
   logic [IDX_W-1:0]     win_idx_q, win_idx_d;
   logic [SCREEN_W-1:0]  screen_q, screen_d;
   logic                 chg_q, chg_d;
   logic                 timeout_q, timeout_d;

   logic                 cnt_load, cnt_dec, cnt_expire, cnt_done;
   logic [CNT_W-1:0]     cnt_load_val, cnt_value;
   logic [MAX_PLAYERS-1:0] fire_ext, wins_ext;
   int unsigned          scr_idx;

   hold_timer #(
      .WIDTH (CNT_W)
   ) u_hold_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .value_o    (cnt_value),
      .expire_o   (cnt_expire)
   );

   // A zero count cannot occur after a load; treat it as expired so the FSM cannot stall.
   assign cnt_done = cnt_expire || (cnt_value == '0);

   always_comb begin
      fire_ext = '0;
      wins_ext = '0;
      fire_ext[NUM_PLAYERS-1:0] = fire_i;
      wins_ext[NUM_PLAYERS-1:0] = wins_i;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StStart;
         show_hit_q <= 1'b0;
         shooter_q  <= '0;
         win_idx_q  <= '0;
         screen_q   <= SCREEN_W'(1);
         chg_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         show_hit_q <= show_hit_d;
         shooter_q  <= shooter_d;
         win_idx_q  <= win_idx_d;
         screen_q   <= screen_d;
         chg_q      <= chg_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      show_hit_d   = show_hit_q;
      shooter_d    = shooter_q;
      win_idx_d    = win_idx_q;
      timeout_d    = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;

      // A win overrides every other event except in WIN, where the winner is frozen.
      if ((state_q != StWin) && (|wins_i)) begin
         state_d   = StWin;
         win_idx_d = IDX_W'(lowest_set(wins_ext));
      end else begin
         unique case (state_q)
            StStart: begin
               if (!start_i) state_d = StPlay;
            end
            StPlay: begin
               if (start_i) begin
                  state_d = StStart;
               end else if (|fire_i) begin
                  state_d      = StWait;
                  shooter_d    = IDX_W'(lowest_set(fire_ext));
                  cnt_load     = 1'b1;
                  cnt_load_val = CNT_W'(RESULT_TIMEOUT);
               end
            end
            StWait: begin
               if (|hit_i) begin
                  state_d      = StShow;
                  show_hit_d   = 1'b1;
                  cnt_load     = 1'b1;
                  cnt_load_val = CNT_W'(HOLD_CYCLES);
               end else if (|miss_i) begin
                  state_d      = StShow;
                  show_hit_d   = 1'b0;
                  cnt_load     = 1'b1;
                  cnt_load_val = CNT_W'(HOLD_CYCLES);
               end else if (cnt_done) begin
                  state_d   = StPlay;
                  timeout_d = 1'b1;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            StShow: begin
               if (start_i) begin
                  state_d = StStart;
               end else if (cnt_done) begin
                  state_d = StPlay;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            StWin: begin
               if (start_i && !(|wins_i)) state_d = StStart;
            end
            default: state_d = StStart;
         endcase
      end
   end

   // Output logic: screen code is decoded from the next state so it lands one clock after the event.
   always_comb begin
      scr_idx = SCR_START;
      unique case (state_d)
         StPlay, StWait: scr_idx = scr_play(NUM_PLAYERS);
         StShow:         scr_idx = show_hit_d ? SCR_HIT : SCR_MISS;
         StWin:          scr_idx = SCR_WIN_BASE + 32'(win_idx_d);
         default:        scr_idx = SCR_START;
      endcase
      screen_d = SCREEN_W'(1) << scr_idx;
      chg_d    = (screen_d != screen_q);
   end

   assign screen_o     = screen_q;
   assign shooter_o    = shooter_q;
   assign screen_chg_o = chg_q;
   assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with N=2, HOLD_CYCLES=4, RESULT_TIMEOUT=8.
module tb_screen_sequencer;

   localparam int unsigned N = 2;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b1;
   logic         start_i = 1'b0;
   logic [N-1:0] fire_i  = '0;
   logic [N-1:0] hit_i   = '0;
   logic [N-1:0] miss_i  = '0;
   logic [N-1:0] wins_i  = '0;
   logic [N+3:0] screen_o;
   logic [0:0]   shooter_o;
   logic         screen_chg_o;
   logic         timeout_o;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   screen_sequencer #(
      .NUM_PLAYERS    (N),
      .HOLD_CYCLES    (4),
      .RESULT_TIMEOUT (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .fire_i       (fire_i),
      .hit_i        (hit_i),
      .miss_i       (miss_i),
      .wins_i       (wins_i),
      .screen_o     (screen_o),
      .shooter_o    (shooter_o),
      .screen_chg_o (screen_chg_o),
      .timeout_o    (timeout_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-hot invariant sampled on every falling edge.
   always @(negedge clk) begin
      n_total++;
      assert ($onehot(screen_o)) n_pass++;
      else $error("FAIL onehot: observed %b expected one-hot", screen_o);
   end

   initial begin
      // Reset
      #1 rst_n = 1'b0;
      start_i = 1'b1;
      #2;
      chk("rst_screen", 32'(screen_o), 32'd1);
      chk("rst_shooter", 32'(shooter_o), 32'd0);
      chk("rst_chg", 32'(screen_chg_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      #20 rst_n = 1'b1;

      // 1. START held, then released into PLAY
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t1_start_screen", 32'(screen_o), 32'd1);
         chk("t1_start_chg", 32'(screen_chg_o), 32'd0);
      end
      start_i = 1'b0;
      step();
      chk("t1_play_screen", 32'(screen_o), 32'd32);
      chk("t1_play_chg", 32'(screen_chg_o), 32'd1);
      step();
      chk("t1_chg_once", 32'(screen_chg_o), 32'd0);

      // 2. fire 01, hit two cycles later, SHOW held 4 cycles, fire in SHOW ignored
      fire_i = 2'b01;
      step();
      fire_i = 2'b00;
      chk("t2_wait_screen", 32'(screen_o), 32'd32);
      chk("t2_shooter", 32'(shooter_o), 32'd0);
      chk("t2_wait_chg", 32'(screen_chg_o), 32'd0);
      step();
      hit_i = 2'b10;
      step();
      hit_i = 2'b00;
      chk("t2_hit_screen", 32'(screen_o), 32'd2);
      chk("t2_hit_chg", 32'(screen_chg_o), 32'd1);
      fire_i = 2'b10;
      step();
      fire_i = 2'b00;
      chk("t2_hold1", 32'(screen_o), 32'd2);
      chk("t2_fire_ignored", 32'(shooter_o), 32'd0);
      step();
      chk("t2_hold2", 32'(screen_o), 32'd2);
      step();
      chk("t2_hold3", 32'(screen_o), 32'd2);
      step();
      chk("t2_back_play", 32'(screen_o), 32'd32);
      chk("t2_back_chg", 32'(screen_chg_o), 32'd1);

      // 3. simultaneous fire, simultaneous hit+miss
      fire_i = 2'b11;
      step();
      fire_i = 2'b00;
      chk("t3_shooter", 32'(shooter_o), 32'd0);
      hit_i  = 2'b01;
      miss_i = 2'b01;
      step();
      hit_i  = 2'b00;
      miss_i = 2'b00;
      chk("t3_hit_wins", 32'(screen_o), 32'd2);
      for (int i = 0; i < 3; i++) step();
      chk("t3_hold_end", 32'(screen_o), 32'd2);
      step();
      chk("t3_back_play", 32'(screen_o), 32'd32);

      // 4. unanswered shot times out after 8 cycles
      fire_i = 2'b10;
      step();
      fire_i = 2'b00;
      chk("t4_shooter", 32'(shooter_o), 32'd1);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("t4_no_timeout", 32'(timeout_o), 32'd0);
      end
      step();
      chk("t4_timeout", 32'(timeout_o), 32'd1);
      chk("t4_screen", 32'(screen_o), 32'd32);
      chk("t4_no_chg", 32'(screen_chg_o), 32'd0);
      step();
      chk("t4_timeout_pulse", 32'(timeout_o), 32'd0);
      fire_i = 2'b01;
      step();
      fire_i = 2'b00;
      chk("t4_next_fire", 32'(shooter_o), 32'd0);

      // 5. win during SHOW(MISS), latched until start
      miss_i = 2'b10;
      step();
      miss_i = 2'b00;
      chk("t5_miss", 32'(screen_o), 32'd4);
      wins_i = 2'b11;
      step();
      chk("t5_win0", 32'(screen_o), 32'd8);
      chk("t5_win_chg", 32'(screen_chg_o), 32'd1);
      wins_i = 2'b00;
      step();
      chk("t5_win_held", 32'(screen_o), 32'd8);
      chk("t5_held_chg", 32'(screen_chg_o), 32'd0);
      start_i = 1'b1;
      step();
      chk("t5_restart", 32'(screen_o), 32'd1);
      start_i = 1'b0;
      step();
      chk("t5_play", 32'(screen_o), 32'd32);

      // Win by player 1 from PLAY; WIN held while start is asserted with wins still high
      wins_i  = 2'b10;
      step();
      chk("t5_win1", 32'(screen_o), 32'd16);
      start_i = 1'b1;
      step();
      chk("t5_win1_held", 32'(screen_o), 32'd16);
      wins_i = 2'b00;
      step();
      chk("t5_win1_exit", 32'(screen_o), 32'd1);
      start_i = 1'b0;
      step();
      chk("t5_play2", 32'(screen_o), 32'd32);

      // start and fire together in PLAY: fire dropped
      start_i = 1'b1;
      fire_i  = 2'b10;
      step();
      fire_i  = 2'b00;
      chk("t5_start_fire_scr", 32'(screen_o), 32'd1);
      chk("t5_start_fire_sht", 32'(shooter_o), 32'd0);
      start_i = 1'b0;
      step();
      chk("t5_play3", 32'(screen_o), 32'd32);

      // 6. asynchronous reset mid-SHOW
      fire_i = 2'b10;
      step();
      fire_i = 2'b00;
      chk("t6_shooter", 32'(shooter_o), 32'd1);
      miss_i = 2'b01;
      step();
      miss_i = 2'b00;
      chk("t6_show", 32'(screen_o), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_screen", 32'(screen_o), 32'd1);
      chk("t6_rst_shooter", 32'(shooter_o), 32'd0);
      chk("t6_rst_chg", 32'(screen_chg_o), 32'd0);
      #1 rst_n = 1'b1;
      step();
      chk("t6_play", 32'(screen_o), 32'd32);
      chk("t6_play_chg", 32'(screen_chg_o), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
